fc_bias_add_ctrl: RTL and testbench

// Sequences one FC-layer bias pass: fetches bias[i] from the single-port bias BRAM in output-neuron order,

---
 rtl/fc_pkg.sv | 58 +++++
 rtl/fc_requant_sat.sv | 44 ++++
 rtl/fc_bias_add_ctrl.sv | 145 ++++++++++++++
 tb/tb_fc_bias_add_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
// Package : fc_pkg
// Brief   : Shared FC-head types and the bias add / requantize / saturate helper.
// Revision: 1.0 - initial release
// ============================================================================
package fc_pkg;

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_PREFETCH = 2'd1;
    localparam logic [1:0] c_ST_RUN      = 2'd2;
    localparam logic [1:0] c_ST_DRAIN    = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = c_ST_IDLE,
        PREFETCH = c_ST_PREFETCH,
        RUN      = c_ST_RUN,
        DRAIN    = c_ST_DRAIN
    } fc_bias_state_e;

    typedef struct packed {
        logic [31:0] value;
        logic        sat;
    } sat_requant_t;

    // 64-bit working width is wide enough that the add can never wrap for
    // accumulators up to 62 bits and outputs up to 32 bits.
    function automatic sat_requant_t sat_requant(
        input logic signed [63:0] acc,
        input logic signed [31:0] bias,
        input int                 frac_bits,
        input int                 data_width
    );
        logic signed [63:0] bias_ext;
        logic signed [63:0] sum;
        logic signed [63:0] q;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        sat_requant_t       res;
        bias_ext  = bias;
        sum       = acc + (bias_ext <<< frac_bits);
        q         = sum >>> frac_bits;
        max_v     = (64'sd1 <<< (data_width - 1)) - 64'sd1;
        min_v     = -(64'sd1 <<< (data_width - 1));
        res.value = q[31:0];
        res.sat   = 1'b0;
        if (q > max_v) begin
            res.value = max_v[31:0];
            res.sat   = 1'b1;
        end else if (q < min_v) begin
            res.value = min_v[31:0];
            res.sat   = 1'b1;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fc_requant_sat.sv
`default_nettype none
// ============================================================================
// Module  : fc_requant_sat
// Brief   : Combinational bias add, requantize, saturate and optional ReLU.
// Revision: 1.0 - initial release
// ============================================================================
module fc_requant_sat
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int FRAC_BITS  = 8,
    parameter int APPLY_RELU = 0
) (
    input  logic [ACC_WIDTH-1:0]  i_acc,
    input  logic [DATA_WIDTH-1:0] i_bias,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_sat
);

    logic signed [63:0]      w_acc_ext;
    logic signed [31:0]      w_bias_ext;
    sat_requant_t            w_res;
    logic [DATA_WIDTH-1:0]   w_clamped;
    logic [31:0]             w_unused_value;

    assign w_acc_ext      = {{(64 - ACC_WIDTH){i_acc[ACC_WIDTH-1]}}, i_acc};
    assign w_bias_ext     = {{(32 - DATA_WIDTH){i_bias[DATA_WIDTH-1]}}, i_bias};
    assign w_res          = sat_requant(w_acc_ext, w_bias_ext, FRAC_BITS, DATA_WIDTH);
    assign w_clamped      = w_res.value[DATA_WIDTH-1:0];
    assign w_unused_value = w_res.value;
    assign o_sat          = w_res.sat;

    // ReLU acts after saturation, so a negative clamp still reports saturation.
    generate
        if (APPLY_RELU != 0) begin : g_relu
            assign o_data = w_clamped[DATA_WIDTH-1] ? '0 : w_clamped;
        end else begin : g_no_relu
            assign o_data = w_clamped;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/fc_bias_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : fc_bias_add_ctrl
// Brief   : Sequences one FC bias pass: bias fetch, add, requantize, stream out.
// Revision: 1.0 - initial release
// ============================================================================
module fc_bias_add_ctrl
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int FRAC_BITS  = 8,
    parameter int OUT_DIM    = 100,
    parameter int APPLY_RELU = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       sat_flag,
    output logic                       bias_rd_en,
    output logic [$clog2(OUT_DIM)-1:0] bias_rd_addr,
    input  logic [DATA_WIDTH-1:0]      bias_rd_data,
    input  logic                       acc_valid,
    output logic                       acc_ready,
    input  logic [ACC_WIDTH-1:0]       acc_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_WIDTH-1:0]      out_data
);

    localparam int                  c_ADDR_W   = $clog2(OUT_DIM);
    localparam logic [c_ADDR_W-1:0] c_LAST_IDX = c_ADDR_W'(OUT_DIM - 1);

    fc_bias_state_e          r_state;
    fc_bias_state_e          w_state_next;
    logic [c_ADDR_W-1:0]     r_idx;
    logic                    r_out_valid;
    logic [DATA_WIDTH-1:0]   r_out_data;
    logic                    r_sat_flag;

    logic                    w_acc_ready;
    logic                    w_accept;
    logic                    w_last;
    logic                    w_start_ok;
    logic                    w_done;
    logic                    w_bias_rd_en;
    logic [c_ADDR_W-1:0]     w_bias_rd_addr;
    logic [DATA_WIDTH-1:0]   w_q;
    logic                    w_q_sat;

    assign w_acc_ready = (r_state == RUN) && (!r_out_valid || out_ready);
    assign w_accept    = acc_valid && w_acc_ready;
    assign w_last      = (r_idx == c_LAST_IDX);
    assign w_start_ok  = (r_state == IDLE) && start;
    assign w_done      = (r_state == DRAIN) && r_out_valid && out_ready;

    fc_requant_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .FRAC_BITS  (FRAC_BITS),
        .APPLY_RELU (APPLY_RELU)
    ) u_requant_sat (
        .i_acc  (acc_data),
        .i_bias (bias_rd_data),
        .o_data (w_q),
        .o_sat  (w_q_sat)
    );

    // Reads are issued in the same cycle as the accept so that the next bias
    // is already on bias_rd_data when the following word can be accepted.
    always_comb begin
        w_state_next   = r_state;
        w_bias_rd_en   = 1'b0;
        w_bias_rd_addr = '0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = PREFETCH;
                    w_bias_rd_en = 1'b1;
                end
            end
            PREFETCH: begin
                w_state_next = RUN;
            end
            RUN: begin
                if (w_accept) begin
                    if (w_last) begin
                        w_state_next = DRAIN;
                    end else begin
                        w_bias_rd_en   = 1'b1;
                        w_bias_rd_addr = r_idx + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (w_done) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_sat_flag  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start_ok) begin
                r_idx      <= '0;
                r_sat_flag <= 1'b0;
            end else if (w_accept) begin
                r_idx <= w_last ? '0 : r_idx + 1'b1;
                if (w_q_sat) begin
                    r_sat_flag <= 1'b1;
                end
            end
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_q;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign busy         = (r_state != IDLE);
    assign done         = w_done;
    assign sat_flag     = r_sat_flag;
    assign bias_rd_en   = w_bias_rd_en;
    assign bias_rd_addr = w_bias_rd_addr;
    assign acc_ready    = w_acc_ready;
    assign out_valid    = r_out_valid;
    assign out_data     = r_out_data;

endmodule
`default_nettype wire

// File: tb/tb_fc_bias_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_fc_bias_add_ctrl
// Brief   : Directed, table-driven bench for fc_bias_add_ctrl with a bias BRAM.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fc_bias_add_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, sat_flag, bias_rd_en;
    logic [1:0]  bias_rd_addr;
    logic [15:0] bias_rd_data = '0;
    logic        acc_valid, acc_ready;
    logic [39:0] acc_data;
    logic        out_valid, out_ready;
    logic [15:0] out_data;
    logic [15:0] mem [4];

    logic        rl_start;
    logic        rl_busy, rl_done, rl_sat_flag, rl_bias_rd_en;
    logic [0:0]  rl_bias_rd_addr;
    logic [15:0] rl_bias_rd_data = '0;
    logic        rl_acc_valid, rl_acc_ready;
    logic [39:0] rl_acc_data;
    logic        rl_out_valid, rl_out_ready;
    logic [15:0] rl_out_data;
    logic [15:0] rl_mem [2];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fc_bias_add_ctrl #(
        .DATA_WIDTH(16), .ACC_WIDTH(40), .FRAC_BITS(8), .OUT_DIM(4), .APPLY_RELU(0)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .sat_flag(sat_flag), .bias_rd_en(bias_rd_en), .bias_rd_addr(bias_rd_addr),
        .bias_rd_data(bias_rd_data), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .acc_data(acc_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data)
    );

    fc_bias_add_ctrl #(
        .DATA_WIDTH(16), .ACC_WIDTH(40), .FRAC_BITS(8), .OUT_DIM(2), .APPLY_RELU(1)
    ) u_relu (
        .clk(clk), .rst(rst), .start(rl_start), .busy(rl_busy), .done(rl_done),
        .sat_flag(rl_sat_flag), .bias_rd_en(rl_bias_rd_en), .bias_rd_addr(rl_bias_rd_addr),
        .bias_rd_data(rl_bias_rd_data), .acc_valid(rl_acc_valid), .acc_ready(rl_acc_ready),
        .acc_data(rl_acc_data), .out_valid(rl_out_valid), .out_ready(rl_out_ready),
        .out_data(rl_out_data)
    );

    // Registered-read bias memories: data appears one cycle after the read.
    always @(posedge clk) begin
        if (bias_rd_en) bias_rd_data <= mem[bias_rd_addr];
        if (rl_bias_rd_en) rl_bias_rd_data <= rl_mem[rl_bias_rd_addr];
    end

    typedef struct packed {
        logic [3:0][39:0] acc;
        logic [3:0][15:0] bias;
        logic [3:0][15:0] exp_out;
        logic             exp_sat;
    } vec_t;

    vec_t tbl [4];

    function automatic vec_t mk(
        input logic [39:0] a0, a1, a2, a3,
        input logic [15:0] b0, b1, b2, b3,
        input logic [15:0] e0, e1, e2, e3,
        input logic        s
    );
        vec_t v;
        v.acc[0] = a0;  v.acc[1] = a1;  v.acc[2] = a2;  v.acc[3] = a3;
        v.bias[0] = b0; v.bias[1] = b1; v.bias[2] = b2; v.bias[3] = b3;
        v.exp_out[0] = e0; v.exp_out[1] = e1; v.exp_out[2] = e2; v.exp_out[3] = e3;
        v.exp_sat = s;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One full pass with a stream driver, output collector and invariant checks.
    task automatic run_pass(input vec_t v, input bit bp, input int restart_cyc);
        int  sent, got, ntr;
        bit  fin;
        logic        stall_prev;
        logic [15:0] data_prev;
        for (int k = 0; k < 4; k++) mem[k] = v.bias[k];
        sent = 0; got = 0; ntr = 0; fin = 0; stall_prev = 1'b0; data_prev = '0;
        for (int cyc = 0; cyc < 60 && !fin; cyc++) begin
            @(negedge clk);
            start     = (cyc == 0) || (cyc == restart_cyc);
            out_ready = bp ? cyc[0] : 1'b1;
            acc_valid = (sent < 4);
            acc_data  = (sent < 4) ? v.acc[sent] : '0;
            #1;
            if (cyc == 1) begin
                chk("sat_cleared", sat_flag, 0);
                chk("prefetch_ready", acc_ready, 0);
            end
            if (cyc == 2 && !bp) chk("first_ready", acc_ready, 1);
            chk("bp_ready_low", out_valid && !out_ready && acc_ready, 0);
            if (stall_prev) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, data_prev);
            end
            stall_prev = out_valid && !out_ready;
            data_prev  = out_data;
            if (bias_rd_en) begin
                chk("rd_addr", bias_rd_addr, ntr);
                ntr++;
            end
            if (acc_valid && acc_ready) sent++;
            if (out_valid && out_ready) begin
                if (got < 4) chk("out_data", out_data, v.exp_out[got]);
                else chk("extra_output", 1, 0);
                got++;
            end
            if (done) begin
                fin = 1;
                chk("done_count", got, 4);
                chk("sat_flag", sat_flag, v.exp_sat);
                chk("rd_count", ntr, 4);
                if (!bp) chk("done_cycle", cyc, 6);
            end
        end
        if (!fin) chk("done_timeout", 0, 1);
        start = 1'b0; acc_valid = 1'b0;
        @(negedge clk); #1;
        chk("idle_busy", busy, 0);
        chk("idle_rd_en", bias_rd_en, 0);
        chk("idle_done", done, 0);
        chk("idle_out_valid", out_valid, 0);
    endtask

    initial begin
        int  rsent, rgot;
        bit  rfin;
        logic [15:0] rl_exp [2];

        rst = 1'b1; start = 1'b0; acc_valid = 1'b0; acc_data = '0; out_ready = 1'b1;
        rl_start = 1'b0; rl_acc_valid = 1'b0; rl_acc_data = '0; rl_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) mem[k] = '0;

        tbl[0] = mk(40'h0, 40'h0, 40'h0, 40'h10000,
                    16'h0100, 16'hFF00, 16'h7FFF, 16'h0000,
                    16'h0100, 16'hFF00, 16'h7FFF, 16'h0100, 1'b0);
        tbl[1] = mk(40'h7FFF00, -40'sh900000, 40'h180, -40'sh180,
                    16'h0100, 16'h0000, 16'h0000, 16'h0000,
                    16'h7FFF, 16'h8000, 16'h0001, 16'hFFFE, 1'b1);
        tbl[2] = mk(40'h80, 40'h80, -40'sh1000, 40'h7FFF00,
                    16'h0001, 16'hFFFF, 16'h0010, 16'h8000,
                    16'h0001, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0);
        tbl[3] = mk(-40'sh100, 40'hFF, 40'h7FFF80, -40'sh800000,
                    16'h8000, 16'h7FFF, 16'h0000, 16'h0000,
                    16'h8000, 16'h7FFF, 16'h7FFF, 16'h8000, 1'b1);

        repeat (3) @(negedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sat", sat_flag, 0);
        chk("rst_rd_en", bias_rd_en, 0);
        chk("rst_rd_addr", bias_rd_addr, 0);
        chk("rst_acc_ready", acc_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        rst = 1'b0;

        run_pass(tbl[0], 1'b0, -1);
        run_pass(tbl[1], 1'b0, -1);
        run_pass(tbl[2], 1'b1, -1);
        run_pass(tbl[3], 1'b0, 3);

        // Abort a pass with idx==2 and an output pending.
        for (int k = 0; k < 4; k++) mem[k] = tbl[0].bias[k];
        @(negedge clk); start = 1'b1; out_ready = 1'b1; acc_valid = 1'b0;
        @(negedge clk); start = 1'b0; acc_valid = 1'b1; acc_data = tbl[0].acc[0];
        @(negedge clk);
        @(negedge clk); acc_data = tbl[0].acc[1];
        @(negedge clk); #1;
        chk("pre_rst_valid", out_valid, 1);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1; acc_valid = 1'b0;
        @(negedge clk); #1;
        chk("abort_busy", busy, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_done", done, 0);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk); #1;
            chk("abort_no_done", done, 0);
        end
        run_pass(tbl[0], 1'b0, -1);

        // ReLU instance.
        rl_mem[0] = 16'h0000; rl_mem[1] = 16'hFFFF;
        rl_exp[0] = 16'h0000; rl_exp[1] = 16'h0001;
        rsent = 0; rgot = 0; rfin = 0;
        for (int cyc = 0; cyc < 30 && !rfin; cyc++) begin
            @(negedge clk);
            rl_start     = (cyc == 0);
            rl_acc_valid = (rsent < 2);
            rl_acc_data  = (rsent == 0) ? -40'sh100 : 40'h200;
            #1;
            if (rl_acc_valid && rl_acc_ready) rsent++;
            if (rl_out_valid && rl_out_ready) begin
                if (rgot < 2) chk("relu_out", rl_out_data, rl_exp[rgot]);
                else chk("relu_extra", 1, 0);
                rgot++;
            end
            if (rl_done) begin
                rfin = 1;
                chk("relu_count", rgot, 2);
                chk("relu_sat", rl_sat_flag, 0);
            end
        end
        if (!rfin) chk("relu_timeout", 0, 1);
        rl_start = 1'b0; rl_acc_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
